// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle ARM control FSM: state encodings,
// datapath select constants and instruction class codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Memory data-phase states are the only ones where byte accesses matter.
    function automatic logic is_mem_access(input state_t s);
        return (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// Combinational next-state function of the multicycle control FSM.
module multicycle_next_state
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [1:0] op_i,
    input  logic       funct_imm_i,
    input  logic       funct_load_i,
    output state_t     state_o
);

    // Next-state selection; any unknown encoding falls back to FETCH.
    always_comb begin
        state_o = S_FETCH;
        case (state_i)
            S_FETCH:  state_o = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_MEM:  state_o = S_MEMADR;
                    OP_DP:   state_o = funct_imm_i ? S_EXECI : S_EXECR;
                    OP_BR:   state_o = S_BRANCH;
                    default: state_o = S_FETCH;
                endcase
            end
            S_MEMADR: state_o = funct_load_i ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_o = S_MEMWB;
            S_MEMWB:  state_o = S_FETCH;
            S_MEMWR:  state_o = S_FETCH;
            S_EXECR:  state_o = S_ALUWB;
            S_EXECI:  state_o = S_ALUWB;
            S_ALUWB:  state_o = S_FETCH;
            S_BRANCH: state_o = S_FETCH;
            default:  state_o = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle ARM datapath: state register plus
// Moore-style decode of per-cycle selects and enables.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       Byte,
    output logic       Done
);

    state_t state_q;
    state_t state_d;
    logic   unused_funct_s;

    assign unused_funct_s = ^{Funct[4:3], Funct[1]};

    multicycle_next_state u_next_state (
        .state_i      (state_q),
        .op_i         (Op),
        .funct_imm_i  (Funct[5]),
        .funct_load_i (Funct[0]),
        .state_o      (state_d)
    );

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state datapath controls; illegal encodings drive everything inactive.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        Byte      = is_mem_access(state_q) ? Funct[2] : 1'b0;
        Done      = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                NextPC    = 1'b1;
            end
            S_DECODE: begin
                // PC+8 for R15 reads; an unsupported class retires here.
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                Done      = (Op == 2'b11);
            end
            S_MEMADR: ALUSrcB = SRCB_EXTIMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
                Done      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                Done   = 1'b1;
            end
            S_EXECR:  ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = SRCB_EXTIMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                RegW = 1'b1;
                Done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
                Done      = 1'b1;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the packed control outputs against hand-written vectors.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, Byte, Done;
    logic [1:0] ALUSrcB, ResultSrc;

    int pass_cnt;
    int total_cnt;

    // Packing: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc NextPC RegW MemW Branch ALUOp Byte Done
    logic [13:0] obs_s;
    assign obs_s = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
                    RegW, MemW, Branch, ALUOp, Byte, Done};

    localparam logic [13:0] V_FETCH    = 14'b1_0_1_10_10_1_0_0_0_0_0_0;
    localparam logic [13:0] V_DECODE   = 14'b0_0_1_10_10_0_0_0_0_0_0_0;
    localparam logic [13:0] V_DEC_DONE = 14'b0_0_1_10_10_0_0_0_0_0_0_1;
    localparam logic [13:0] V_MEMADR   = 14'b0_0_0_01_00_0_0_0_0_0_0_0;
    localparam logic [13:0] V_MEMRD_W  = 14'b0_1_0_00_00_0_0_0_0_0_0_0;
    localparam logic [13:0] V_MEMWB    = 14'b0_0_0_00_01_0_1_0_0_0_0_1;
    localparam logic [13:0] V_MEMWR_W  = 14'b0_1_0_00_00_0_0_1_0_0_0_1;
    localparam logic [13:0] V_MEMWR_B  = 14'b0_1_0_00_00_0_0_1_0_0_1_1;
    localparam logic [13:0] V_EXECR    = 14'b0_0_0_00_00_0_0_0_0_1_0_0;
    localparam logic [13:0] V_EXECI    = 14'b0_0_0_01_00_0_0_0_0_1_0_0;
    localparam logic [13:0] V_ALUWB    = 14'b0_0_0_00_00_0_1_0_0_0_0_1;
    localparam logic [13:0] V_BRANCH   = 14'b0_0_0_01_10_0_0_0_1_0_0_1;

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .Byte      (Byte),
        .Done      (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [13:0] exp);
        total_cnt++;
        assert (obs_s === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs_s, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        Op        = 2'b00;
        Funct     = 6'b000000;
        #1;
        check("rst_async", V_FETCH);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold", V_FETCH);
        end

        // LDR: 5 cycles, word access
        Op = 2'b01; Funct = 6'b011001;
        reset = 1'b0;
        #1; check("ldr_fetch", V_FETCH);
        tick(); check("ldr_decode", V_DECODE);
        tick(); check("ldr_memadr", V_MEMADR);
        tick(); check("ldr_memrd", V_MEMRD_W);
        tick(); check("ldr_memwb", V_MEMWB);

        // STRB: 4 cycles, byte store
        tick(); Op = 2'b01; Funct = 6'b011100;
        #1; check("strb_fetch", V_FETCH);
        tick(); check("strb_decode", V_DECODE);
        tick(); check("strb_memadr", V_MEMADR);
        tick(); check("strb_memwr", V_MEMWR_B);

        // ADD register
        tick(); Op = 2'b00; Funct = 6'b001000;
        #1; check("add_fetch", V_FETCH);
        tick(); check("add_decode", V_DECODE);
        tick(); check("add_execr", V_EXECR);
        tick(); check("add_aluwb", V_ALUWB);

        // EOR immediate
        tick(); Op = 2'b00; Funct = 6'b100011;
        #1; check("eor_fetch", V_FETCH);
        tick(); check("eor_decode", V_DECODE);
        tick(); check("eor_execi", V_EXECI);
        tick(); check("eor_aluwb", V_ALUWB);

        // B
        tick(); Op = 2'b10; Funct = 6'b100000;
        #1; check("b_fetch", V_FETCH);
        tick(); check("b_decode", V_DECODE);
        tick(); check("b_branch", V_BRANCH);

        // Unsupported Op=11 retires in DECODE
        tick(); Op = 2'b11; Funct = 6'b000000;
        #1; check("op11_fetch", V_FETCH);
        tick(); check("op11_decode", V_DEC_DONE);
        tick(); check("op11_next_fetch", V_FETCH);

        // STR aborted by reset in MEMADR, away from any clock edge
        Op = 2'b01; Funct = 6'b011000;
        tick(); check("str_decode", V_DECODE);
        tick(); check("str_memadr", V_MEMADR);
        #2; reset = 1'b1;
        #1; check("abort_async", V_FETCH);
        tick(); check("abort_hold", V_FETCH);
        tick(); check("abort_hold2", V_FETCH);

        // Next instruction after release: STR word completes normally
        reset = 1'b0;
        #1; check("post_fetch", V_FETCH);
        tick(); check("post_decode", V_DECODE);
        tick(); check("post_memadr", V_MEMADR);
        tick(); check("post_memwr", V_MEMWR_W);
        tick(); check("post_fetch2", V_FETCH);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control state machine for the multicycle variant of the ARM datapath. Sequences one instruction over 3–5 cycles on a shared memory and ALU: fetch, decode, then a class-specific path for data-processing, memory or branch. Emits Moore-style per-cycle select and enable signals to the datapath and condition logic. Combinational ALU/flag decoding stays in the existing decoder; this block drives only its `ALUOp` input.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Op` in 2: instruction bits [27:26], sampled from the instruction register.
- `Funct` in 6: instruction bits [25:20]; [5]=I, [2]=B, [0]=L/S.
- `IRWrite` out 1: load instruction register.
- `AdrSrc` out 1: memory address select; 0=PC, 1=ALUOut.
- `ALUSrcA` out 1: ALU A operand; 0=RD1, 1=PC.
- `ALUSrcB` out 2: ALU B operand; 00=RD2, 01=ExtImm, 10=constant 4.
- `ResultSrc` out 2: result select; 00=ALUOut, 01=Data, 10=ALUResult.
- `NextPC` out 1: unconditional PC write.
- `RegW` out 1: register write request, gated by condition logic.
- `MemW` out 1: memory write request, gated by condition logic.
- `Branch` out 1: branch PC-write request, gated by condition logic.
- `ALUOp` out 1: 1 = ALU function decoded from `Funct`, 0 = add.
- `byte` out 1: byte access; equals `Funct[2]` in MEMRD/MEMWR, else 0.
- `Done` out 1: high in the final cycle of each instruction.

## Operation
- Ten states, 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10–15 are illegal and return to FETCH.
- State transitions:
  - FETCH → DECODE.
  - DECODE, by `Op`:
    - 01 → MEMADR.
    - 00 → EXECI if `Funct[5]`, else EXECR.
    - 10 → BRANCH.
    - 11 → FETCH, with `Done`=1 (unsupported instruction, no side effects).
  - MEMADR → MEMRD if `Funct[0]`, else MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECR and EXECI → ALUWB → FETCH.
  - BRANCH → FETCH.
- Outputs per state. Any signal not listed is 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. This computes PC+8 for the R15 read.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1, byte=`Funct[2]`.
  - MEMWB: ResultSrc=01, RegW=1, Done=1.
  - MEMWR: AdrSrc=1, MemW=1, byte=`Funct[2]`, Done=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1, Done=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, Done=1.
- `Op` and `Funct` are stable from DECODE onward, because IR is loaded only in FETCH. The block does not register them.
- Condition evaluation is outside this block. The block never suppresses `RegW`, `MemW` or `Branch` itself.

## Timing
- State register updates on the rising edge of `clk`. Outputs are combinational from state, plus `Funct[2]` for `byte`; there are no output registers.
- `reset` asserted: state = FETCH immediately, no clock needed. Outputs therefore take FETCH values during reset: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, all others 0. The datapath holds its own registers in reset, so these requests have no effect.
- First FETCH cycle occurs on the first rising edge after `reset` deasserts.
- Cycles per instruction:
  - LDR: 5.
  - STR: 4.
  - data-processing: 4.
  - branch: 3.
  - Op=11: 2.
- `Done` is high for exactly one cycle per instruction; the next cycle is FETCH.
- Reset mid-instruction aborts it. No `Done` is issued, and no write-enable is asserted after reset asserts.

## Structure
- Shared package: state encodings, ALUSrcB/ResultSrc select constants, Op class constants (DP=00, MEM=01, BR=10).
- One sub-module, `multicycle_next_state`: purely combinational next-state function of (state, `Op`, `Funct[5]`, `Funct[0]`).
- Output decode is a single case on state in the top module.

## Test plan
- Reset held 3 cycles, then released: state=FETCH throughout reset, with IRWrite=1, NextPC=1, MemW=0, RegW=0.
- LDR (`Op`=01, `Funct`=011001): FETCH→DECODE→MEMADR→MEMRD→MEMWB; `byte`=0 in MEMRD; RegW=1 and ResultSrc=01 only in cycle 5; `Done` in cycle 5.
- STRB (`Op`=01, `Funct`=011100): 4 cycles; MemW=1, AdrSrc=1 and `byte`=1 in cycle 4 only.
- ADD register then EOR immediate (`Op`=00, `Funct`=001000 then 100011):
  - ADD path EXECR, with ALUSrcB=00.
  - EOR path EXECI, with ALUSrcB=01.
  - ALUOp=1 only in the execute cycle; RegW in ALUWB.
- B (`Op`=10), then `Op`=11:
  - B: 3 cycles, Branch=1 with ALUSrcB=01 in cycle 3.
  - Op=11: 2 cycles, `Done` in DECODE, no write-enables.
- Async reset asserted mid-cycle during MEMADR of a store: state returns to FETCH without a clock edge; MemW never asserts; the next instruction fetches normally after release.
